control_mag_sync: RTL and testbench
===================================

Name: control_mag_sync

Overview:
- Magnetron-enable control for the microwave controller: a set/reset state bit driving the magnetron output Q.
- Q is set by a start request while the door is closed and no stop condition is active.
- Q is cleared by door open, stop, clear or timer expiry.
- Sits between the keypad/door/timer blocks and the magnetron driver. Fully synchronous, with optional input synchronizers for asynchronous button/sensor inputs.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each control input (legal 0..4; 0 = inputs used directly, already synchronous).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- resetn  input  1  synchronous active-low reset
- startn  input  1  start request, active low
- stopn  input  1  stop request, active low
- clearn  input  1  clear request, active low
- door_closed  input  1  1 = door closed, 0 = door open
- timer_done  input  1  1 = cook timer expired
- Q  output  1  magnetron enable, registered, 1 = on

Behaviour:
- Reset: resetn sampled low at a rising clk edge forces Q=0 and all synchronizer flops to their inactive values: startn=1, stopn=1, clearn=1, door_closed=0, timer_done=0. Reset has top priority.
- Input path: each input passes through its own SYNC_STAGES-deep flop chain. s_* denotes the synchronized values.
- Clear condition: clr = (s_door_closed==0) | (s_stopn==0) | (s_clearn==0) | (s_timer_done==1).
- Set condition: set = (s_startn==0) & ~clr.
- Clear dominates set; a start held while any clear source is active never turns Q on.
- Next state each edge: if clr then Q<=0; else if set then Q<=1; else Q holds.
- Hold: once on, Q stays 1 after startn returns high, until a clear source occurs.
- Once cleared, Q stays 0 after the clear source is removed. A new startn-low sample is required to turn it on again. A startn held low continuously re-sets Q on the first edge after clr deasserts.
- Latency: an input change affects Q at the (SYNC_STAGES+1)th rising edge after it is stable. That is 3 cycles at the default and 1 cycle at SYNC_STAGES=0.
- Simultaneous events:
  - startn low with door open → Q=0.
  - startn low with stopn low, clearn low, or timer_done high → Q=0.
- Door opening mid-operation clears Q with the same latency. Closing the door again does not restart Q without startn low.
- Reset mid-operation: Q=0 on the reset edge, and the synchronizers are flushed. After release, Q remains 0 until a valid start is synchronized through.
- No combinational path from any input to Q. Q is a flop output.

Decomposition:
- Shared package: constants for the inactive input levels (START_INACTIVE=1, DOOR_OPEN=0, etc.) and the SYNC_STAGES default.
- One sub-module, sync_chain (parameter STAGES, RESET_VAL; ports clk, resetn, d, q), instantiated once per input.
- The sync_chain instances are bypassed via generate when STAGES=0.
- The top level holds only the clr/set logic and the Q register.

Test Plan:
- Door-interlock start: reset, then startn=0 with door_closed=0 for 10 cycles → Q=0. Set door_closed=1 → Q=1 after 3 cycles. Release startn=1 → Q stays 1.
- Door open: Q=1, set door_closed=0 → Q=0 after 3 cycles. Set door_closed=1 → Q stays 0.
- Stop and clear: from Q=1, pulse stopn=0 for 10 cycles → Q=0 and stays 0 after release. Repeat with a clearn=0 pulse → same result.
- Timer: from Q=1, timer_done=1 for 10 cycles then 0 → Q=0 and stays 0.
- Blocked start: hold each of stopn=0, clearn=0 and timer_done=1 in turn, with door_closed=1 and a startn=0 pulse during each → Q=0 throughout.
- Reset: from Q=1 assert resetn=0 for one edge → Q=0 on that edge. Release with startn=1 → Q stays 0. Repeat the door-interlock start with SYNC_STAGES=0 → 1-cycle latency.

Source files
------------

// File: rtl/control_mag_sync_pkg.sv
// Shared constants and types for the magnetron-enable controller.
// Inactive levels double as the synchronizer reset values.
package control_mag_sync_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic START_INACTIVE = 1'b1;
  localparam logic STOP_INACTIVE  = 1'b1;
  localparam logic CLEAR_INACTIVE = 1'b1;
  localparam logic DOOR_OPEN      = 1'b0;
  localparam logic TIMER_IDLE     = 1'b0;

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;

  typedef struct packed {
    logic startn;
    logic stopn;
    logic clearn;
    logic door_closed;
    logic timer_done;
  } mag_ctrl_t;

  // Any single clear source is enough to force the magnetron off.
  function automatic logic clear_active(mag_ctrl_t c);
    return (c.door_closed == DOOR_OPEN) | (c.stopn != STOP_INACTIVE) |
           (c.clearn != CLEAR_INACTIVE) | (c.timer_done != TIMER_IDLE);
  endfunction

endpackage

// File: rtl/control_mag_sync_if.sv
// Control inputs and magnetron enable between keypad/door/timer and the driver.
interface control_mag_sync_if;
  logic startn;
  logic stopn;
  logic clearn;
  logic door_closed;
  logic timer_done;
  logic Q;

  modport master (
    output startn, stopn, clearn, door_closed, timer_done,
    input  Q
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done,
    output Q
  );
endinterface

// File: rtl/control_mag_sync_sync_chain.sv
// Flop chain synchronizer for one asynchronous control input.
// Reset loads the input's inactive level into every stage.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r <= {STAGES{RESET_VAL}};
    end else begin
      r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r[i] <= r[i-1];
      end
    end
  end

  assign q = r[STAGES-1];

endmodule

// File: rtl/control_mag_sync.sv
// Magnetron-enable set/reset bit: start sets, any clear source clears.
//   state  | meaning
//   ST_OFF | magnetron disabled (reset, door open, stop, clear, timer done)
//   ST_ON  | magnetron enabled after a start with the door closed
module control_mag_sync
  import control_mag_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  control_mag_sync_if.slave   mag
);

  logic s_startn;
  logic s_stopn;
  logic s_clearn;
  logic s_door_closed;
  logic s_timer_done;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s_startn      = mag.startn;
      assign s_stopn       = mag.stopn;
      assign s_clearn      = mag.clearn;
      assign s_door_closed = mag.door_closed;
      assign s_timer_done  = mag.timer_done;
    end else begin : g_sync
      sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(START_INACTIVE)) u_startn (
        .clk(clk), .resetn(resetn), .d(mag.startn), .q(s_startn)
      );
      sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(STOP_INACTIVE)) u_stopn (
        .clk(clk), .resetn(resetn), .d(mag.stopn), .q(s_stopn)
      );
      sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(CLEAR_INACTIVE)) u_clearn (
        .clk(clk), .resetn(resetn), .d(mag.clearn), .q(s_clearn)
      );
      sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(DOOR_OPEN)) u_door_closed (
        .clk(clk), .resetn(resetn), .d(mag.door_closed), .q(s_door_closed)
      );
      sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(TIMER_IDLE)) u_timer_done (
        .clk(clk), .resetn(resetn), .d(mag.timer_done), .q(s_timer_done)
      );
    end
  endgenerate

  mag_ctrl_t  s_ctrl;
  logic       clr;
  logic       set;
  logic [0:0] state;

  assign s_ctrl = '{startn:      s_startn,
                    stopn:       s_stopn,
                    clearn:      s_clearn,
                    door_closed: s_door_closed,
                    timer_done:  s_timer_done};

  // Clear dominates: a held start cannot override an active clear source.
  assign clr = clear_active(s_ctrl);
  assign set = (s_ctrl.startn != START_INACTIVE) & ~clr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_OFF;
    end else if (clr) begin
      state <= ST_OFF;
    end else if (set) begin
      state <= ST_ON;
    end
  end

  assign mag.Q = state[0];

endmodule

// File: tb/tb_control_mag_sync.sv
// Bench for control_mag_sync: default-depth and bypassed instances share stimulus.
module tb_control_mag_sync;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  control_mag_sync_if if2 ();
  control_mag_sync_if if0 ();

  control_mag_sync #(.SYNC_STAGES(2)) u_dut2 (.clk(clk), .resetn(resetn), .mag(if2));
  control_mag_sync #(.SYNC_STAGES(0)) u_dut0 (.clk(clk), .resetn(resetn), .mag(if0));

  typedef struct {
    string name;
    logic  startn;
    logic  stopn;
    logic  clearn;
    logic  door;
    logic  timer;
    int    cycles;
    logic  exp_q;
    bit    every;
  } vec_t;

  vec_t vecs[$];
  logic sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got Q=%b expected Q=%b", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic cl,
                       input logic dr, input logic tm);
    if2.startn = st; if2.stopn = sp; if2.clearn = cl; if2.door_closed = dr; if2.timer_done = tm;
    if0.startn = st; if0.stopn = sp; if0.clearn = cl; if0.door_closed = dr; if0.timer_done = tm;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic st, input logic sp, input logic cl,
                     input logic dr, input logic tm, input int cyc, input logic q, input bit ev);
    vec_t v;
    v.name = nm; v.startn = st; v.stopn = sp; v.clearn = cl; v.door = dr; v.timer = tm;
    v.cycles = cyc; v.exp_q = q; v.every = ev;
    vecs.push_back(v);
  endtask

  initial begin
    logic exp;

    //   name             st sp cl dr tm cyc q every
    add("door_open_start", 0, 1, 1, 0, 0, 10, 0, 1);
    add("door_close_start",0, 1, 1, 1, 0, 6,  1, 0);
    add("start_release",   1, 1, 1, 1, 0, 6,  1, 0);
    add("door_open",       1, 1, 1, 0, 0, 6,  0, 0);
    add("door_reclose",    1, 1, 1, 1, 0, 6,  0, 1);
    add("restart1",        0, 1, 1, 1, 0, 6,  1, 0);
    add("restart1_rel",    1, 1, 1, 1, 0, 6,  1, 0);
    add("stop_pulse",      1, 0, 1, 1, 0, 10, 0, 0);
    add("stop_rel",        1, 1, 1, 1, 0, 6,  0, 1);
    add("restart2",        0, 1, 1, 1, 0, 6,  1, 0);
    add("restart2_rel",    1, 1, 1, 1, 0, 6,  1, 0);
    add("clear_pulse",     1, 1, 0, 1, 0, 10, 0, 0);
    add("clear_rel",       1, 1, 1, 1, 0, 6,  0, 1);
    add("restart3",        0, 1, 1, 1, 0, 6,  1, 0);
    add("restart3_rel",    1, 1, 1, 1, 0, 6,  1, 0);
    add("timer_pulse",     1, 1, 1, 1, 1, 10, 0, 0);
    add("timer_rel",       1, 1, 1, 1, 0, 6,  0, 1);
    add("blk_stop_hold",   1, 0, 1, 1, 0, 6,  0, 1);
    add("blk_stop_start",  0, 0, 1, 1, 0, 6,  0, 1);
    add("blk_stop_srel",   1, 0, 1, 1, 0, 6,  0, 1);
    add("blk_stop_rel",    1, 1, 1, 1, 0, 6,  0, 1);
    add("blk_clr_hold",    1, 1, 0, 1, 0, 6,  0, 1);
    add("blk_clr_start",   0, 1, 0, 1, 0, 6,  0, 1);
    add("blk_clr_srel",    1, 1, 0, 1, 0, 6,  0, 1);
    add("blk_clr_rel",     1, 1, 1, 1, 0, 6,  0, 1);
    add("blk_tmr_hold",    1, 1, 1, 1, 1, 6,  0, 1);
    add("blk_tmr_start",   0, 1, 1, 1, 1, 6,  0, 1);
    add("blk_tmr_srel",    1, 1, 1, 1, 1, 6,  0, 1);
    add("blk_tmr_rel",     1, 1, 1, 1, 0, 6,  0, 1);
    add("held_start",      0, 1, 1, 1, 0, 6,  1, 0);
    add("held_stop",       0, 0, 1, 1, 0, 6,  0, 0);
    add("held_reset",      0, 1, 1, 1, 0, 6,  1, 0);
    add("final_rel",       1, 1, 1, 1, 0, 6,  1, 0);

    resetn = 1'b0;
    drive(1, 1, 1, 0, 0);
    tick(2);
    check("reset_s2", if2.Q, 1'b0);
    check("reset_s0", if0.Q, 1'b0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].startn, vecs[i].stopn, vecs[i].clearn, vecs[i].door, vecs[i].timer);
      sb.push_back(vecs[i].exp_q);
      for (int c = 0; c < vecs[i].cycles; c++) begin
        tick(1);
        if (vecs[i].every && c < vecs[i].cycles - 1) begin
          check({vecs[i].name, "_cyc_s2"}, if2.Q, vecs[i].exp_q);
          check({vecs[i].name, "_cyc_s0"}, if0.Q, vecs[i].exp_q);
        end
      end
      exp = sb.pop_front();
      check({vecs[i].name, "_s2"}, if2.Q, exp);
      check({vecs[i].name, "_s0"}, if0.Q, exp);
    end

    // Reset from Q=1 takes effect on the reset edge itself.
    resetn = 1'b0;
    tick(1);
    check("rst_edge_s2", if2.Q, 1'b0);
    check("rst_edge_s0", if0.Q, 1'b0);
    resetn = 1'b1;
    tick(6);
    check("rst_rel_s2", if2.Q, 1'b0);
    check("rst_rel_s0", if0.Q, 1'b0);

    // Start latency: 1 edge bypassed, 3 edges with two sync stages.
    drive(0, 1, 1, 1, 0);
    tick(1);
    check("lat_start_e1_s0", if0.Q, 1'b1);
    check("lat_start_e1_s2", if2.Q, 1'b0);
    tick(1);
    check("lat_start_e2_s2", if2.Q, 1'b0);
    tick(1);
    check("lat_start_e3_s2", if2.Q, 1'b1);
    drive(1, 1, 1, 1, 0);
    tick(3);

    // Door-open latency.
    drive(1, 1, 1, 0, 0);
    tick(1);
    check("lat_door_e1_s0", if0.Q, 1'b0);
    check("lat_door_e1_s2", if2.Q, 1'b1);
    tick(1);
    check("lat_door_e2_s2", if2.Q, 1'b1);
    tick(1);
    check("lat_door_e3_s2", if2.Q, 1'b0);

    // A start caught mid-chain must be flushed by reset.
    drive(1, 1, 1, 1, 0);
    tick(4);
    drive(0, 1, 1, 1, 0);
    tick(1);
    resetn = 1'b0;
    drive(1, 1, 1, 1, 0);
    tick(1);
    check("flush_edge_s2", if2.Q, 1'b0);
    check("flush_edge_s0", if0.Q, 1'b0);
    resetn = 1'b1;
    tick(5);
    check("flush_after_s2", if2.Q, 1'b0);
    check("flush_after_s0", if0.Q, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
